// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the data-memory bus controller: FSM encoding,
// full-word byte enable and the byte-lane enable helper.
package mem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BE_WORD = 4'hF;

    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/mbc_lane_sel.sv
// Byte-lane steering: enables and replicated data for stores, lane
// extraction (right-justified, zero-filled) for loads. Purely combinational.
module mbc_lane_sel
    import mem_bus_ctrl_pkg::*;
(
    input  logic        wr_byte,
    input  logic [1:0]  wr_lane,
    input  logic [31:0] store_data,
    input  logic        rd_byte,
    input  logic [1:0]  rd_lane,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rword
);

    assign be    = wr_byte ? lane_be(wr_lane) : BE_WORD;
    assign wdata = wr_byte ? {4{store_data[7:0]}} : store_data;
    assign rword = rd_byte ? {24'b0, rdata[{rd_lane, 3'b000} +: 8]} : rdata;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Data-memory access controller: turns EX/MEM load/store requests into a
// req/ack bus transaction, stalls the pipeline and hands the read word to MEM.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        ByteOp,
    input  logic [31:0] Address,
    input  logic [31:0] StoreData,
    input  logic        PipeHold,
    output logic        StallReq,
    output logic        RAMReadEnable,
    output logic [31:0] RAMData,
    output logic        AddrError,
    output logic        BusError,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [3:0]  BusBe,
    output logic [31:0] BusWData,
    input  logic        BusAck,
    input  logic [31:0] BusRData
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [1:0]       lane_q;
    logic             byte_q;
    logic             read_q;

    logic             mis;
    logic             access;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic [31:0]      rd_word;

    assign mis    = ~ByteOp & (Address[1:0] != 2'b00);
    assign access = (MemRead | MemWrite) & ~mis;

    // Stall starts combinationally in IDLE so the request is held from its first cycle.
    assign StallReq      = (state == ST_REQ) | ((state == ST_IDLE) & access);
    assign AddrError     = (state == ST_IDLE) & (MemRead | MemWrite) & mis;
    assign RAMReadEnable = (state == ST_DONE) & read_q;

    mbc_lane_sel u_lane_sel (
        .wr_byte    (ByteOp),
        .wr_lane    (Address[1:0]),
        .store_data (StoreData),
        .rd_byte    (byte_q),
        .rd_lane    (lane_q),
        .rdata      (BusRData),
        .be         (wr_be),
        .wdata      (wr_data),
        .rword      (rd_word)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            lane_q   <= 2'b00;
            byte_q   <= 1'b0;
            read_q   <= 1'b0;
            BusReq   <= 1'b0;
            BusWe    <= 1'b0;
            BusAddr  <= '0;
            BusBe    <= '0;
            BusWData <= '0;
            RAMData  <= '0;
            BusError <= 1'b0;
        end else begin
            BusError <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        BusAddr  <= {Address[31:2], 2'b00};
                        BusWe    <= MemWrite;
                        BusBe    <= wr_be;
                        BusWData <= wr_data;
                        read_q   <= MemRead;
                        lane_q   <= Address[1:0];
                        byte_q   <= ByteOp;
                        BusReq   <= 1'b1;
                        count    <= '0;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // An ack arriving on the final timeout cycle still completes normally.
                    if (BusAck) begin
                        BusReq <= 1'b0;
                        if (read_q) begin
                            RAMData <= rd_word;
                        end
                        state <= ST_DONE;
                    end else if (count == TIMEOUT_LAST) begin
                        BusReq   <= 1'b0;
                        RAMData  <= '0;
                        BusError <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!PipeHold) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: stimulus queues expected bus/MEM results,
// a negedge monitor compares them as each transaction is presented and completes.
module tb_mem_bus_ctrl;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic        ByteOp;
    logic [31:0] Address;
    logic [31:0] StoreData;
    logic        PipeHold;
    logic        StallReq;
    logic        RAMReadEnable;
    logic [31:0] RAMData;
    logic        AddrError;
    logic        BusError;
    logic        BusReq;
    logic        BusWe;
    logic [31:0] BusAddr;
    logic [3:0]  BusBe;
    logic [31:0] BusWData;
    logic        BusAck;
    logic [31:0] BusRData;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        ren;
        logic [31:0] rdata;
        logic        berr;
        int          req_cycles;
        bit          abort;
    } exp_t;

    exp_t exp_q[$];
    int   asserts = 0;
    int   fails   = 0;

    int          ack_k    = 0;
    logic [31:0] ack_data = '0;
    int          resp_cnt = 0;
    int          mon_req  = 0;
    logic        prev_req = 1'b0;
    bit          berr_check = 1'b0;

    mem_bus_ctrl #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .ByteOp        (ByteOp),
        .Address       (Address),
        .StoreData     (StoreData),
        .PipeHold      (PipeHold),
        .StallReq      (StallReq),
        .RAMReadEnable (RAMReadEnable),
        .RAMData       (RAMData),
        .AddrError     (AddrError),
        .BusError      (BusError),
        .BusReq        (BusReq),
        .BusWe         (BusWe),
        .BusAddr       (BusAddr),
        .BusBe         (BusBe),
        .BusWData      (BusWData),
        .BusAck        (BusAck),
        .BusRData      (BusRData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        asserts++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, actual, expected);
        end
    endtask

    // Bus slave: acks in REQ cycle ack_k (0 = never), counted from the first cycle BusReq is seen.
    always @(negedge clk) begin
        if (BusReq) begin
            resp_cnt++;
            if (ack_k != 0 && resp_cnt == ack_k) begin
                BusAck   = 1'b1;
                BusRData = ack_data;
            end else begin
                BusAck   = 1'b0;
                BusRData = 32'h0;
            end
        end else begin
            resp_cnt = 0;
            BusAck   = 1'b0;
            BusRData = 32'h0;
        end
    end

    // Monitor: checks bus fields every REQ cycle and MEM-side results once BusReq drops.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (berr_check) begin
            checkOutput("BusError pulse clears", 32'(BusError), 32'h0);
            berr_check = 1'b0;
        end
        if (BusReq) begin
            mon_req++;
            if (exp_q.size() == 0) begin
                checkOutput("no unexpected BusReq", 32'(BusReq), 32'h0);
            end else begin
                checkOutput("BusAddr", BusAddr, exp_q[0].addr);
                checkOutput("BusWe", 32'(BusWe), 32'(exp_q[0].we));
                checkOutput("BusBe", 32'(BusBe), 32'(exp_q[0].be));
                checkOutput("BusWData", BusWData, exp_q[0].wdata);
            end
        end else if (prev_req && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.abort) begin
                checkOutput("reset BusAddr", BusAddr, 32'h0);
                checkOutput("reset BusBe", 32'(BusBe), 32'h0);
                checkOutput("reset BusWData", BusWData, 32'h0);
                checkOutput("reset BusWe", 32'(BusWe), 32'h0);
                checkOutput("reset RAMData", RAMData, 32'h0);
                checkOutput("reset BusError", 32'(BusError), 32'h0);
            end else begin
                checkOutput("REQ cycle count", 32'(mon_req), 32'(e.req_cycles));
                checkOutput("RAMReadEnable", 32'(RAMReadEnable), 32'(e.ren));
                checkOutput("RAMData", RAMData, e.rdata);
                checkOutput("BusError", 32'(BusError), 32'(e.berr));
                berr_check = 1'b1;
            end
            mon_req = 0;
        end
        prev_req = BusReq;
    end

    task automatic applyStimulus(input string name, input logic rd, input logic wr, input logic bop,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input int k, input logic [31:0] rdata,
                                 input logic [3:0] ebe, input logic [31:0] ewdata,
                                 input logic [31:0] erdata, input logic eberr,
                                 input int ereq, input int hold);
        exp_t e;
        int   stall;
        int   guard;
        e.addr       = {addr[31:2], 2'b00};
        e.we         = wr;
        e.be         = ebe;
        e.wdata      = ewdata;
        e.ren        = rd;
        e.rdata      = erdata;
        e.berr       = eberr;
        e.req_cycles = ereq;
        e.abort      = 1'b0;
        @(negedge clk);
        ack_k     = k;
        ack_data  = rdata;
        exp_q.push_back(e);
        MemRead   = rd;
        MemWrite  = wr;
        ByteOp    = bop;
        Address   = addr;
        StoreData = sdata;
        PipeHold  = (hold > 0);
        #1;
        stall = 0;
        guard = 0;
        while (StallReq === 1'b1 && guard < 64) begin
            stall++;
            guard++;
            @(negedge clk);
            #1;
        end
        checkOutput({name, " StallReq cycles"}, 32'(stall), 32'(ereq + 1));
        repeat (hold) begin
            @(negedge clk);
            #1;
            checkOutput({name, " held RAMData"}, RAMData, erdata);
            checkOutput({name, " held BusReq"}, 32'(BusReq), 32'h0);
            checkOutput({name, " held RAMReadEnable"}, 32'(RAMReadEnable), 32'(rd));
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        PipeHold = 1'b0;
    endtask

    task automatic applyAddrError(input string name, input logic rd, input logic wr, input logic [31:0] addr);
        @(negedge clk);
        MemRead  = rd;
        MemWrite = wr;
        ByteOp   = 1'b0;
        Address  = addr;
        #1;
        checkOutput({name, " AddrError"}, 32'(AddrError), 32'h1);
        checkOutput({name, " StallReq"}, 32'(StallReq), 32'h0);
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput({name, " BusReq"}, 32'(BusReq), 32'h0);
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        #1;
        checkOutput({name, " AddrError idle"}, 32'(AddrError), 32'h0);
    endtask

    task automatic applyAbort(input logic [31:0] addr);
        exp_t e;
        e.addr       = addr;
        e.we         = 1'b0;
        e.be         = 4'hF;
        e.wdata      = 32'h0;
        e.ren        = 1'b1;
        e.rdata      = 32'h0;
        e.berr       = 1'b0;
        e.req_cycles = 0;
        e.abort      = 1'b1;
        @(negedge clk);
        ack_k     = 0;
        exp_q.push_back(e);
        MemRead   = 1'b1;
        ByteOp    = 1'b0;
        Address   = addr;
        StoreData = 32'h0;
        @(negedge clk);
        #1;
        checkOutput("abort StallReq in REQ", 32'(StallReq), 32'h1);
        reset   = 1'b0;
        MemRead = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("abort StallReq", 32'(StallReq), 32'h0);
        checkOutput("abort RAMReadEnable", 32'(RAMReadEnable), 32'h0);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("abort no retry", 32'(BusReq), 32'h0);
        end
    endtask

    initial begin
        reset     = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        ByteOp    = 1'b0;
        Address   = 32'h0;
        StoreData = 32'h0;
        PipeHold  = 1'b0;
        BusAck    = 1'b0;
        BusRData  = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst BusReq", 32'(BusReq), 32'h0);
        checkOutput("rst BusWe", 32'(BusWe), 32'h0);
        checkOutput("rst BusAddr", BusAddr, 32'h0);
        checkOutput("rst BusBe", 32'(BusBe), 32'h0);
        checkOutput("rst BusWData", BusWData, 32'h0);
        checkOutput("rst RAMData", RAMData, 32'h0);
        checkOutput("rst BusError", 32'(BusError), 32'h0);
        checkOutput("rst StallReq", 32'(StallReq), 32'h0);
        checkOutput("rst RAMReadEnable", 32'(RAMReadEnable), 32'h0);
        reset = 1'b1;

        //             name   rd    wr    bop   addr          sdata         k  rdata         be       wdata         rdata-exp     berr  req hold
        applyStimulus("LW",   1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        2, 32'hDEADBEEF, 4'hF,    32'h0,        32'hDEADBEEF, 1'b0, 2, 0);
        applyStimulus("LB3",  1'b1, 1'b0, 1'b1, 32'h0000_0203, 32'h11223344, 1, 32'h12345678, 4'b1000, 32'h44444444, 32'h00000012, 1'b0, 1, 0);
        applyStimulus("SB2",  1'b0, 1'b1, 1'b1, 32'h0000_0302, 32'h000000AB, 3, 32'h0,        4'b0100, 32'hABABABAB, 32'h00000012, 1'b0, 3, 0);
        applyStimulus("SW",   1'b0, 1'b1, 1'b0, 32'h0000_0404, 32'hCAFEF00D, 1, 32'h0,        4'hF,    32'hCAFEF00D, 32'h00000012, 1'b0, 1, 0);
        applyStimulus("LB0",  1'b1, 1'b0, 1'b1, 32'h0000_0500, 32'h0,        1, 32'hA1B2C3D4, 4'b0001, 32'h0,        32'h000000D4, 1'b0, 1, 0);
        applyStimulus("LB1",  1'b1, 1'b0, 1'b1, 32'h0000_0601, 32'h0,        2, 32'hA1B2C3D4, 4'b0010, 32'h0,        32'h000000C3, 1'b0, 2, 0);

        applyAddrError("LW misaligned", 1'b1, 1'b0, 32'h0000_0105);
        applyAddrError("SW misaligned", 1'b0, 1'b1, 32'h0000_0102);

        applyStimulus("TMO",  1'b1, 1'b0, 1'b0, 32'h0000_0700, 32'h0,        0, 32'h0,        4'hF,    32'h0,        32'h00000000, 1'b1, 4, 0);
        applyStimulus("ACK4", 1'b1, 1'b0, 1'b0, 32'h0000_0704, 32'h0,        4, 32'h55AA55AA, 4'hF,    32'h0,        32'h55AA55AA, 1'b0, 4, 0);

        applyAbort(32'h0000_0900);

        applyStimulus("HOLD", 1'b1, 1'b0, 1'b0, 32'h0000_0108, 32'h0,        1, 32'h0BADF00D, 4'hF,    32'h0,        32'h0BADF00D, 1'b0, 1, 3);
        applyStimulus("SB3",  1'b0, 1'b1, 1'b1, 32'h0000_0003, 32'hFFFFFF5A, 1, 32'h0,        4'b1000, 32'h5A5A5A5A, 32'h0BADF00D, 1'b0, 1, 0);

        repeat (4) @(negedge clk);
        #3;
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
